writeback_queue: RTL and testbench

Parametrised in-order writeback buffer between the memory stage and the register file. It holds up to DEPTH retiring instructions, each with two result lanes. It absorbs variable-latency load responses through a valid/ready handshake, and aligns and optionally sign-extends sub-word loads. Entries drain in program order into registered register-file write ports, and the block publishes a pending-write scoreboard mask for hazard detection in decode.

---
 rtl/writeback_queue_if.sv | 49 ++++
 rtl/writeback_queue.sv | 210 +++++++++++++++++++++
 tb/tb_writeback_queue.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_queue_if.sv
// Writeback queue bus bundle: memory-stage enqueue, load response and register-file write ports.
interface writeback_queue_if #(
  parameter int unsigned REGS = 32
);
  localparam int unsigned TW = $clog2(REGS);

  // Memory stage enqueue handshake
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_tgt1;
  logic [TW-1:0] in_tgt2;
  logic [31:0]   in_res1;
  logic [31:0]   in_res2;
  logic          in_is_load;
  logic          in_is_store;
  logic          in_no_wb;
  logic [1:0]    in_size;
  logic          in_signed;
  logic [1:0]    in_addr_lo;

  // Load response handshake
  logic          mem_rsp_valid;
  logic          mem_rsp_ready;
  logic [31:0]   mem_rsp_data;

  // Register file write ports
  logic          we1;
  logic          we2;
  logic [TW-1:0] wb_tgt1;
  logic [TW-1:0] wb_tgt2;
  logic [31:0]   wb_data1;
  logic [31:0]   wb_data2;

  modport master (
    output in_valid, in_tgt1, in_tgt2, in_res1, in_res2,
    output in_is_load, in_is_store, in_no_wb, in_size, in_signed, in_addr_lo,
    output mem_rsp_valid, mem_rsp_data,
    input  in_ready, mem_rsp_ready,
    input  we1, we2, wb_tgt1, wb_tgt2, wb_data1, wb_data2
  );

  modport slave (
    input  in_valid, in_tgt1, in_tgt2, in_res1, in_res2,
    input  in_is_load, in_is_store, in_no_wb, in_size, in_signed, in_addr_lo,
    input  mem_rsp_valid, mem_rsp_data,
    output in_ready, mem_rsp_ready,
    output we1, we2, wb_tgt1, wb_tgt2, wb_data1, wb_data2
  );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback buffer: absorbs load responses, aligns sub-word loads and
// retires entries in program order onto registered register-file write ports.
module writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned REGS  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt,
  writeback_queue_if.slave       bus,
  output logic [REGS-1:0]        pending_mask,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned TW = $clog2(REGS);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // One queued instruction; res1 is overwritten by the raw load word on response
  typedef struct packed {
    logic          valid;
    logic          have_data;
    logic [TW-1:0] tgt1;
    logic [TW-1:0] tgt2;
    logic [31:0]   res1;
    logic [31:0]   res2;
    logic          is_load;
    logic          is_store;
    logic          no_wb;
    logic [1:0]    size;
    logic          sgn;
    logic [1:0]    addr_lo;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          we1_q, we1_d;
  logic          we2_q, we2_d;
  logic [TW-1:0] wb_tgt1_q, wb_tgt1_d;
  logic [TW-1:0] wb_tgt2_q, wb_tgt2_d;
  logic [31:0]   wb_data1_q, wb_data1_d;
  logic [31:0]   wb_data2_q, wb_data2_d;

  logic          in_ready_c;
  logic          rsp_ready_c;
  logic          enq_c;
  logic          rsp_c;
  logic          ret_c;
  logic          fill_found_c;
  logic [AW-1:0] fill_ptr_c;
  entry_t        head_ent_c;

  // Extract and extend the addressed half/byte of a load word
  function automatic logic [31:0] align_load(input logic [31:0] d,
                                             input logic [1:0]  size,
                                             input logic        sgn,
                                             input logic [1:0]  a);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = '0;
    b = '0;
    r = d;
    case (size)
      2'd1: begin
        case (a)
          2'b00:   h = d[15:0];
          2'b01:   h = d[23:8];
          default: h = d[31:16];
        endcase
        r = {{16{sgn & h[15]}}, h};
      end
      2'd2: begin
        b = d[{a, 3'b000} +: 8];
        r = {{24{sgn & b[7]}}, b};
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Fill pointer: oldest queued load still waiting for data, found by walking from head
  always_comb begin
    fill_found_c = 1'b0;
    fill_ptr_c   = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (!fill_found_c &&
          ent_q[head_q + AW'(i)].valid &&
          ent_q[head_q + AW'(i)].is_load &&
          !ent_q[head_q + AW'(i)].have_data) begin
        fill_found_c = 1'b1;
        fill_ptr_c   = head_q + AW'(i);
      end
    end
  end

  // Handshake qualifiers; halt blocks every state change
  assign head_ent_c  = ent_q[head_q];
  assign in_ready_c  = (count_q < CW'(DEPTH)) && !halt;
  assign rsp_ready_c = fill_found_c && !halt;
  assign enq_c       = bus.in_valid && in_ready_c;
  assign rsp_c       = bus.mem_rsp_valid && rsp_ready_c;
  assign ret_c       = head_ent_c.valid && head_ent_c.have_data && !halt;

  // Next state: independent enqueue at tail, response fill, and retire at head
  always_comb begin
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    we1_d      = 1'b0;
    we2_d      = 1'b0;
    wb_tgt1_d  = wb_tgt1_q;
    wb_tgt2_d  = wb_tgt2_q;
    wb_data1_d = wb_data1_q;
    wb_data2_d = wb_data2_q;

    if (enq_c) begin
      ent_d[tail_q] = '{valid:     1'b1,
                        have_data: !bus.in_is_load,
                        tgt1:      bus.in_tgt1,
                        tgt2:      bus.in_tgt2,
                        res1:      bus.in_res1,
                        res2:      bus.in_res2,
                        is_load:   bus.in_is_load,
                        is_store:  bus.in_is_store,
                        no_wb:     bus.in_no_wb,
                        size:      bus.in_size,
                        sgn:       bus.in_signed,
                        addr_lo:   bus.in_addr_lo};
      tail_d = tail_q + AW'(1);
    end

    if (rsp_c) begin
      ent_d[fill_ptr_c].have_data = 1'b1;
      ent_d[fill_ptr_c].res1      = bus.mem_rsp_data;
    end

    if (ret_c) begin
      ent_d[head_q].valid = 1'b0;
      head_d     = head_q + AW'(1);
      we1_d      = (head_ent_c.tgt1 != '0) && !head_ent_c.is_store && !head_ent_c.no_wb;
      we2_d      = (head_ent_c.tgt2 != '0) && !head_ent_c.no_wb;
      wb_tgt1_d  = head_ent_c.tgt1;
      wb_tgt2_d  = head_ent_c.tgt2;
      wb_data1_d = head_ent_c.is_load
                 ? align_load(head_ent_c.res1, head_ent_c.size, head_ent_c.sgn, head_ent_c.addr_lo)
                 : head_ent_c.res1;
      wb_data2_d = head_ent_c.res2;
    end

    count_d = count_q + CW'(enq_c) - CW'(ret_c);
  end

  // State and write-port registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      we1_q      <= 1'b0;
      we2_q      <= 1'b0;
      wb_tgt1_q  <= '0;
      wb_tgt2_q  <= '0;
      wb_data1_q <= '0;
      wb_data2_q <= '0;
    end else begin
      ent_q      <= ent_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      we1_q      <= we1_d;
      we2_q      <= we2_d;
      wb_tgt1_q  <= wb_tgt1_d;
      wb_tgt2_q  <= wb_tgt2_d;
      wb_data1_q <= wb_data1_d;
      wb_data2_q <= wb_data2_d;
    end
  end

  // Scoreboard of registers with a queued write; r0 is never reported
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && !ent_q[i].no_wb) begin
        if ((ent_q[i].tgt1 != '0) && !ent_q[i].is_store) pending_mask[ent_q[i].tgt1] = 1'b1;
        if (ent_q[i].tgt2 != '0) pending_mask[ent_q[i].tgt2] = 1'b1;
      end
    end
    pending_mask[0] = 1'b0;
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.mem_rsp_ready = rsp_ready_c;
  assign bus.we1           = we1_q;
  assign bus.we2           = we2_q;
  assign bus.wb_tgt1       = wb_tgt1_q;
  assign bus.wb_tgt2       = wb_tgt2_q;
  assign bus.wb_data1      = wb_data1_q;
  assign bus.wb_data2      = wb_data2_q;
  assign count             = count_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus a randomized run
// against a transaction-level queue model.
module tb_writeback_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned REGS  = 32;
  localparam int unsigned TW    = 5;
  localparam int unsigned CW    = 3;

  typedef struct {
    logic [TW-1:0] t1;
    logic [TW-1:0] t2;
    logic [31:0]   r1;
    logic [31:0]   r2;
    logic [31:0]   d;
    logic          ld;
    logic          st;
    logic          nw;
    logic          sg;
    logic          have;
    logic [1:0]    sz;
    logic [1:0]    a;
  } m_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            halt;
  logic [REGS-1:0] pending_mask;
  logic [CW-1:0]   count;
  int              checks = 0;
  int              errors = 0;

  writeback_queue_if #(.REGS(REGS)) bus ();

  writeback_queue #(.DEPTH(DEPTH), .REGS(REGS)) dut (
    .clk          (clk),
    .rst          (rst),
    .halt         (halt),
    .bus          (bus),
    .pending_mask (pending_mask),
    .count        (count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.in_tgt1       = '0;
    bus.in_tgt2       = '0;
    bus.in_res1       = '0;
    bus.in_res2       = '0;
    bus.in_is_load    = 1'b0;
    bus.in_is_store   = 1'b0;
    bus.in_no_wb      = 1'b0;
    bus.in_size       = 2'd0;
    bus.in_signed     = 1'b0;
    bus.in_addr_lo    = 2'd0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  task automatic set_op(input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic ld, input logic st, input logic nw,
                        input logic [1:0] sz, input logic sg, input logic [1:0] a);
    bus.in_valid    = 1'b1;
    bus.in_tgt1     = t1;
    bus.in_tgt2     = t2;
    bus.in_res1     = r1;
    bus.in_res2     = r2;
    bus.in_is_load  = ld;
    bus.in_is_store = st;
    bus.in_no_wb    = nw;
    bus.in_size     = sz;
    bus.in_signed   = sg;
    bus.in_addr_lo  = a;
  endtask

  // Reference load extraction using shifts and masks
  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] a);
    logic [31:0] v;
    int          sh;
    if (sz == 2'd1) begin
      sh = (a == 2'd0) ? 0 : (a == 2'd1) ? 8 : 16;
      v  = (d >> sh) & 32'h0000_FFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else if (sz == 2'd2) begin
      sh = 8 * int'(a);
      v  = (d >> sh) & 32'h0000_00FF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = d;
    end
    return v;
  endfunction

  task automatic test_reset();
    idle_inputs();
    halt = 1'b0;
    rst  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if ({bus.we1, bus.we2} !== 2'b00) begin errors++; $display("FAIL reset_we got=%b exp=00", {bus.we1, bus.we2}); end
    checks++; if ({bus.wb_tgt1, bus.wb_tgt2} !== '0) begin errors++; $display("FAIL reset_tgt got=%0d/%0d exp=0/0", bus.wb_tgt1, bus.wb_tgt2); end
    checks++; if ({bus.wb_data1, bus.wb_data2} !== 64'd0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", bus.wb_data1, bus.wb_data2); end
    checks++; if (pending_mask !== '0) begin errors++; $display("FAIL reset_mask got=%h exp=0", pending_mask); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.mem_rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready got=%b exp=0", bus.mem_rsp_ready); end
  endtask

  task automatic test_alu_op();
    set_op(5'd5, 5'd0, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    idle_inputs();
    checks++; if (bus.we1 !== 1'b0) begin errors++; $display("FAIL alu_early_we1 got=%b exp=0", bus.we1); end
    checks++; if (pending_mask !== 32'h0000_0020) begin errors++; $display("FAIL alu_mask got=%h exp=00000020", pending_mask); end
    tick();
    checks++; if (bus.we1 !== 1'b1 || bus.wb_tgt1 !== 5'd5) begin errors++; $display("FAIL alu_we1 got=%b/%0d exp=1/5", bus.we1, bus.wb_tgt1); end
    checks++; if (bus.wb_data1 !== 32'h1234) begin errors++; $display("FAIL alu_data1 got=%h exp=00001234", bus.wb_data1); end
    checks++; if (bus.we2 !== 1'b0) begin errors++; $display("FAIL alu_we2 got=%b exp=0", bus.we2); end
    tick();
    checks++; if (bus.we1 !== 1'b0 || bus.wb_data1 !== 32'h1234) begin errors++; $display("FAIL alu_hold got=%b/%h exp=0/00001234", bus.we1, bus.wb_data1); end
    checks++; if (count !== CW'(0)) begin errors++; $display("FAIL alu_count got=%0d exp=0", count); end
  endtask

  task automatic test_loads();
    logic [31:0] rsp_t [6] = '{32'h80FF_0000, 32'h80FF_0000, 32'hAABB_CCDD, 32'h8001_1234, 32'hDEAD_BEEF, 32'h1234_567F};
    logic [1:0]  sz_t  [6] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd2};
    logic [1:0]  a_t   [6] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd2, 2'd0};
    logic        sg_t  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exp_t [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BBCC, 32'hFFFF_8001, 32'hDEAD_BEEF, 32'h0000_007F};
    for (int i = 0; i < 6; i++) begin
      set_op(5'd9, 5'd0, 32'h5555_5555, 32'h0, 1'b1, 1'b0, 1'b0, sz_t[i], sg_t[i], a_t[i]);
      tick();
      idle_inputs();
      #1;
      checks++; if (bus.mem_rsp_ready !== 1'b1) begin errors++; $display("FAIL load%0d_rsp_ready got=%b exp=1", i, bus.mem_rsp_ready); end
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = rsp_t[i];
      tick();
      bus.mem_rsp_valid = 1'b0;
      checks++; if (bus.we1 !== 1'b0) begin errors++; $display("FAIL load%0d_early got=%b exp=0", i, bus.we1); end
      tick();
      checks++; if (bus.we1 !== 1'b1 || bus.wb_tgt1 !== 5'd9) begin errors++; $display("FAIL load%0d_we got=%b/%0d exp=1/9", i, bus.we1, bus.wb_tgt1); end
      checks++; if (bus.wb_data1 !== exp_t[i]) begin errors++; $display("FAIL load%0d_data got=%h exp=%h", i, bus.wb_data1, exp_t[i]); end
    end
    tick();
  endtask

  task automatic test_load_then_alu();
    set_op(5'd3, 5'd0, 32'hBAD0_0000, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    set_op(5'd4, 5'd0, 32'h44, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({bus.we1, bus.we2} !== 2'b00) begin errors++; $display("FAIL lta_wait%0d got=%b exp=00", i, {bus.we1, bus.we2}); end
    end
    checks++; if (pending_mask !== 32'h0000_0018) begin errors++; $display("FAIL lta_mask got=%h exp=00000018", pending_mask); end
    checks++; if (count !== CW'(2)) begin errors++; $display("FAIL lta_count got=%0d exp=2", count); end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h33;
    tick();
    bus.mem_rsp_valid = 1'b0;
    tick();
    checks++; if (bus.we1 !== 1'b1 || bus.wb_tgt1 !== 5'd3 || bus.wb_data1 !== 32'h33) begin errors++; $display("FAIL lta_r3 got=%b/%0d/%h exp=1/3/00000033", bus.we1, bus.wb_tgt1, bus.wb_data1); end
    tick();
    checks++; if (bus.we1 !== 1'b1 || bus.wb_tgt1 !== 5'd4 || bus.wb_data1 !== 32'h44) begin errors++; $display("FAIL lta_r4 got=%b/%0d/%h exp=1/4/00000044", bus.we1, bus.wb_tgt1, bus.wb_data1); end
    tick();
    checks++; if (pending_mask !== '0) begin errors++; $display("FAIL lta_mask_clear got=%h exp=0", pending_mask); end
  endtask

  task automatic test_store();
    set_op(5'd7, 5'd2, 32'h77, 32'h22, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    idle_inputs();
    checks++; if (pending_mask !== 32'h0000_0004) begin errors++; $display("FAIL store_mask got=%h exp=00000004", pending_mask); end
    tick();
    checks++; if ({bus.we1, bus.we2} !== 2'b01) begin errors++; $display("FAIL store_we got=%b exp=01", {bus.we1, bus.we2}); end
    checks++; if (bus.wb_tgt2 !== 5'd2 || bus.wb_data2 !== 32'h22) begin errors++; $display("FAIL store_lane2 got=%0d/%h exp=2/00000022", bus.wb_tgt2, bus.wb_data2); end
    set_op(5'd7, 5'd2, 32'h77, 32'h22, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0);
    tick();
    idle_inputs();
    checks++; if (pending_mask !== '0) begin errors++; $display("FAIL nowb_mask got=%h exp=0", pending_mask); end
    tick();
    checks++; if ({bus.we1, bus.we2} !== 2'b00) begin errors++; $display("FAIL nowb_we got=%b exp=00", {bus.we1, bus.we2}); end
  endtask

  task automatic test_halt();
    set_op(5'd6, 5'd0, 32'h66, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    halt = 1'b1;
    set_op(5'd8, 5'd0, 32'h88, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL halt_in_ready got=%b exp=0", bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.we1 !== 1'b0 || count !== CW'(1)) begin errors++; $display("FAIL halt_frozen%0d got=we%b/cnt%0d exp=we0/cnt1", i, bus.we1, count); end
    end
    checks++; if (pending_mask !== 32'h0000_0040) begin errors++; $display("FAIL halt_mask got=%h exp=00000040", pending_mask); end
    halt = 1'b0;
    idle_inputs();
    tick();
    checks++; if (bus.we1 !== 1'b1 || bus.wb_tgt1 !== 5'd6 || bus.wb_data1 !== 32'h66) begin errors++; $display("FAIL halt_resume got=%b/%0d/%h exp=1/6/00000066", bus.we1, bus.wb_tgt1, bus.wb_data1); end
    tick();
    checks++; if (count !== CW'(0) || bus.we1 !== 1'b0) begin errors++; $display("FAIL halt_empty got=cnt%0d/we%b exp=cnt0/we0", count, bus.we1); end
  endtask

  task automatic test_full_wrap();
    set_op(5'd1, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    for (int i = 1; i < DEPTH; i++) begin
      set_op(TW'(i + 1), 5'd0, 32'h100 + 32'(i), 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
      tick();
    end
    idle_inputs();
    #1;
    checks++; if (count !== CW'(DEPTH) || bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_state got=cnt%0d/rdy%b exp=cnt%0d/rdy0", count, bus.in_ready, DEPTH); end
    set_op(5'd20, 5'd0, 32'hBAD, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hABCD_0001;
    tick();
    bus.mem_rsp_valid = 1'b0;
    checks++; if (count !== CW'(DEPTH) || bus.we1 !== 1'b0) begin errors++; $display("FAIL full_rsp got=cnt%0d/we%b exp=cnt%0d/we0", count, bus.we1, DEPTH); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass got=%b exp=0", bus.in_ready); end
    tick();
    idle_inputs();
    checks++; if (count !== CW'(DEPTH - 1)) begin errors++; $display("FAIL full_reject got=%0d exp=%0d", count, DEPTH - 1); end
    checks++; if (bus.we1 !== 1'b1 || bus.wb_tgt1 !== 5'd1 || bus.wb_data1 !== 32'hABCD_0001) begin errors++; $display("FAIL full_head got=%b/%0d/%h exp=1/1/abcd0001", bus.we1, bus.wb_tgt1, bus.wb_data1); end
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      checks++; if (bus.wb_tgt1 !== TW'(i + 1) || bus.wb_data1 !== 32'h100 + 32'(i)) begin errors++; $display("FAIL full_drain%0d got=%0d/%h exp=%0d/%h", i, bus.wb_tgt1, bus.wb_data1, i + 1, 32'h100 + 32'(i)); end
    end
    for (int i = 0; i < 3 * DEPTH; i++) begin
      set_op(TW'((i % 30) + 1), 5'd0, 32'h2000 + 32'(i), 32'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
      tick();
      if (i > 0) begin
        checks++; if (bus.we1 !== 1'b1 || bus.wb_data1 !== 32'h2000 + 32'(i - 1)) begin errors++; $display("FAIL wrap%0d got=%b/%h exp=1/%h", i, bus.we1, bus.wb_data1, 32'h2000 + 32'(i - 1)); end
      end
    end
    idle_inputs();
    tick();
    checks++; if (bus.wb_data1 !== 32'h2000 + 32'(3 * DEPTH - 1) || count !== CW'(0)) begin errors++; $display("FAIL wrap_last got=%h/cnt%0d exp=%h/cnt0", bus.wb_data1, count, 32'h2000 + 32'(3 * DEPTH - 1)); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      set_op(TW'(10 + i), 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
      tick();
    end
    idle_inputs();
    checks++; if (count !== CW'(3) || pending_mask !== 32'h0000_1C00) begin errors++; $display("FAIL rmid_pre got=cnt%0d/%h exp=cnt3/00001c00", count, pending_mask); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (count !== CW'(0) || {bus.we1, bus.we2} !== 2'b00) begin errors++; $display("FAIL rmid_state got=cnt%0d/we%b exp=cnt0/we00", count, {bus.we1, bus.we2}); end
    checks++; if (pending_mask !== '0 || bus.mem_rsp_ready !== 1'b0) begin errors++; $display("FAIL rmid_mask got=%h/rsp%b exp=0/rsp0", pending_mask, bus.mem_rsp_ready); end
  endtask

  task automatic test_random();
    m_t            mq[$];
    m_t            e;
    logic [TW-1:0] et1, et2;
    logic [31:0]   ewd1, ewd2;
    logic          ewe1, ewe2, exp_in_ready, exp_rsp_ready, ret, enq, rsp;
    logic [REGS-1:0] emask;
    int            fidx;
    idle_inputs();
    halt = 1'b0;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
    et1 = '0; et2 = '0; ewd1 = '0; ewd2 = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      halt              = ($urandom_range(0, 99) < 8);
      bus.in_valid      = ($urandom_range(0, 99) < 60);
      bus.in_tgt1       = TW'($urandom_range(0, 31));
      bus.in_tgt2       = TW'($urandom_range(0, 31));
      bus.in_res1       = $urandom;
      bus.in_res2       = $urandom;
      bus.in_is_load    = ($urandom_range(0, 99) < 40);
      bus.in_is_store   = ($urandom_range(0, 99) < 15);
      bus.in_no_wb      = ($urandom_range(0, 99) < 10);
      bus.in_size       = 2'($urandom_range(0, 3));
      bus.in_signed     = 1'($urandom_range(0, 1));
      bus.in_addr_lo    = 2'($urandom_range(0, 3));
      bus.mem_rsp_valid = ($urandom_range(0, 99) < 45);
      bus.mem_rsp_data  = $urandom;
      #1;
      fidx = -1;
      foreach (mq[k]) if (fidx < 0 && mq[k].ld && !mq[k].have) fidx = k;
      emask = '0;
      foreach (mq[k]) begin
        if (!mq[k].nw) begin
          if (mq[k].t1 != 0 && !mq[k].st) emask[mq[k].t1] = 1'b1;
          if (mq[k].t2 != 0) emask[mq[k].t2] = 1'b1;
        end
      end
      emask[0]      = 1'b0;
      exp_in_ready  = (mq.size() < DEPTH) && !halt;
      exp_rsp_ready = (fidx >= 0) && !halt;
      checks++; if (bus.in_ready !== exp_in_ready) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, exp_in_ready); end
      checks++; if (bus.mem_rsp_ready !== exp_rsp_ready) begin errors++; $display("FAIL rnd_rsp_ready cyc=%0d got=%b exp=%b", cyc, bus.mem_rsp_ready, exp_rsp_ready); end
      checks++; if (count !== CW'(mq.size())) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size()); end
      checks++; if (pending_mask !== emask) begin errors++; $display("FAIL rnd_mask cyc=%0d got=%h exp=%h", cyc, pending_mask, emask); end
      ret  = !halt && (mq.size() > 0) && mq[0].have;
      enq  = bus.in_valid && exp_in_ready;
      rsp  = bus.mem_rsp_valid && exp_rsp_ready;
      ewe1 = 1'b0;
      ewe2 = 1'b0;
      if (rsp) begin
        mq[fidx].have = 1'b1;
        mq[fidx].d    = bus.mem_rsp_data;
      end
      if (ret) begin
        e    = mq.pop_front();
        ewe1 = (e.t1 != 0) && !e.st && !e.nw;
        ewe2 = (e.t2 != 0) && !e.nw;
        et1  = e.t1;
        et2  = e.t2;
        ewd1 = e.ld ? ref_load(e.d, e.sz, e.sg, e.a) : e.r1;
        ewd2 = e.r2;
      end
      if (enq) begin
        e.t1 = bus.in_tgt1;    e.t2 = bus.in_tgt2;
        e.r1 = bus.in_res1;    e.r2 = bus.in_res2;
        e.ld = bus.in_is_load; e.st = bus.in_is_store; e.nw = bus.in_no_wb;
        e.sz = bus.in_size;    e.sg = bus.in_signed;   e.a  = bus.in_addr_lo;
        e.have = !bus.in_is_load;
        e.d    = '0;
        mq.push_back(e);
      end
      tick();
      checks++; if ({bus.we1, bus.we2} !== {ewe1, ewe2}) begin errors++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", cyc, {bus.we1, bus.we2}, {ewe1, ewe2}); end
      checks++; if (bus.wb_tgt1 !== et1 || bus.wb_tgt2 !== et2) begin errors++; $display("FAIL rnd_tgt cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, bus.wb_tgt1, bus.wb_tgt2, et1, et2); end
      checks++; if (bus.wb_data1 !== ewd1) begin errors++; $display("FAIL rnd_data1 cyc=%0d got=%h exp=%h", cyc, bus.wb_data1, ewd1); end
      checks++; if (bus.wb_data2 !== ewd2) begin errors++; $display("FAIL rnd_data2 cyc=%0d got=%h exp=%h", cyc, bus.wb_data2, ewd2); end
    end
    halt = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst  = 1'b1;
    halt = 1'b0;
    idle_inputs();
    test_reset();
    test_alu_op();
    test_loads();
    test_load_then_alu();
    test_store();
    test_halt();
    test_full_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
